// File: rtl/rv_fp_normalize_pkg.sv
// Shared definitions for the FP normalisation stage.
// Holds the RISC-V frm encodings, the default FP32 field widths and the
// exponent-saturation limit used to detect pre-round overflow.
package rv_fp_normalize_pkg;

  localparam logic [2:0] INST_FRM_RNE = 3'b000;
  localparam logic [2:0] INST_FRM_RTZ = 3'b001;
  localparam logic [2:0] INST_FRM_RDN = 3'b010;
  localparam logic [2:0] INST_FRM_RUP = 3'b011;
  localparam logic [2:0] INST_FRM_RMM = 3'b100;
  localparam logic [2:0] INST_FRM_DYN = 3'b111;

  localparam int FP_EXP_BITS = 8;
  localparam int FP_MAN_BITS = 23;
  localparam int FP_EXP_MAX  = 2**FP_EXP_BITS - 1;

  // Largest biased exponent field value (all ones) for a given field width.
  function automatic int exp_max(input int exp_bits);
    return (1 << exp_bits) - 1;
  endfunction

endpackage

// File: rtl/rv_fp_lzc.sv
// Combinational leading-zero counter.
// Ports:
//   data  - vector to scan, MSB first
//   cnt   - number of leading zeros (WIDTH when data is all zero)
//   zero  - high when data is all zero
module rv_fp_lzc #(
  parameter  int WIDTH = 51,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/rv_fp_normalize.sv
// Two-stage normalisation ahead of the FPU rounding stage.
// S1 counts leading zeros of the raw magnitude sum and registers it with the
// exponent and side-band. S2 shifts the sum into normal or subnormal position,
// packs {exp, mant}, extracts {round, sticky} and flags exponent overflow.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   valid_i / ready_o   - input handshake
//   sum_i, exp_i        - magnitude sum (MSB weighs 2^(exp_i+1)), biased exponent
//   sticky_i            - OR of bits already discarded upstream
//   sign_i, rnd_mode_i, eff_sub_i, tag_i - side-band carried to the output
//   valid_o / ready_i   - output handshake
//   abs_value_o         - unrounded {exp, mant}
//   round_sticky_o      - {round, sticky}
//   sign_o, rnd_mode_o, eff_sub_o, tag_o - registered side-band
//   overflow_o          - exponent reached the all-ones encoding before rounding
module rv_fp_normalize
  import rv_fp_normalize_pkg::*;
#(
  parameter int EXP_BITS = FP_EXP_BITS,
  parameter int MAN_BITS = FP_MAN_BITS,
  parameter int SUM_W    = 2*(MAN_BITS+1)+3,
  parameter int TAG_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [SUM_W-1:0]             sum_i,
  input  logic [EXP_BITS:0]            exp_i,
  input  logic                         sticky_i,
  input  logic                         sign_i,
  input  logic [2:0]                   rnd_mode_i,
  input  logic                         eff_sub_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [EXP_BITS+MAN_BITS-1:0] abs_value_o,
  output logic [1:0]                   round_sticky_o,
  output logic                         sign_o,
  output logic [2:0]                   rnd_mode_o,
  output logic                         eff_sub_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic                         overflow_o
);

  localparam int LZW     = $clog2(SUM_W + 1);
  localparam int CW      = ((LZW > EXP_BITS + 1) ? LZW : EXP_BITS + 1) + 1;
  localparam int EXP_MAX = exp_max(EXP_BITS);
  localparam int RS_W    = SUM_W - 1 - MAN_BITS;

  function automatic logic [EXP_BITS+MAN_BITS-1:0] pack_sat(
    input logic [CW-1:0]       e,
    input logic [MAN_BITS-1:0] mant
  );
    if (e >= CW'(EXP_MAX)) return {{EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
    return {e[EXP_BITS-1:0], mant};
  endfunction

  function automatic logic [1:0] round_sticky(
    input logic [RS_W-1:0] lo,
    input logic            sticky_in,
    input logic            ovf
  );
    if (ovf) return 2'b00;
    return {lo[RS_W-1], (|lo[RS_W-2:0]) | sticky_in};
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 s2_ready;
  logic [SUM_W-1:0]     sum_p1;
  logic [EXP_BITS:0]    exp_p1;
  logic [LZW-1:0]       lzc_p1;
  logic                 zero_p1, sticky_p1, sign_p1, eff_sub_p1;
  logic [2:0]           rnd_mode_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic [LZW-1:0]       lzc_p0;
  logic                 zero_p0;

  assign s2_ready = ~vld_p2 | ready_i;
  assign ready_o  = ~vld_p1 | s2_ready;

  rv_fp_lzc #(.WIDTH(SUM_W)) u_lzc (
    .data (sum_i),
    .cnt  (lzc_p0),
    .zero (zero_p0)
  );

  // ---- S1: leading-zero count and operand capture ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      sum_p1      <= '0;
      exp_p1      <= '0;
      lzc_p1      <= '0;
      zero_p1     <= 1'b0;
      sticky_p1   <= 1'b0;
      sign_p1     <= 1'b0;
      rnd_mode_p1 <= '0;
      eff_sub_p1  <= 1'b0;
      tag_p1      <= '0;
    end else if (ready_o) begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        sum_p1      <= sum_i;
        exp_p1      <= exp_i;
        lzc_p1      <= lzc_p0;
        zero_p1     <= zero_p0;
        sticky_p1   <= sticky_i;
        sign_p1     <= sign_i;
        rnd_mode_p1 <= rnd_mode_i;
        eff_sub_p1  <= eff_sub_i;
        tag_p1      <= tag_i;
      end
    end
  end

  // ---- S2: shift, pack, round/sticky extraction ----
  logic [CW-1:0]    lzc_w, exp_w, shamt_w, e_w;
  logic [SUM_W-2:0] frac_sh;
  logic             ovf_w;

  // A zero sum always takes the zero path so a large exponent cannot leak
  // into the packed result of an exact zero.
  always_comb begin
    lzc_w = CW'(lzc_p1);
    exp_w = CW'(exp_p1);
    if (!zero_p1 && (lzc_w <= exp_w)) begin
      shamt_w = lzc_w;
      e_w     = exp_w + CW'(1) - lzc_w;
    end else begin
      shamt_w = (exp_w > CW'(SUM_W)) ? CW'(SUM_W) : exp_w;
      e_w     = '0;
    end
  end

  // The leading (hidden) bit falls off the top; only the fraction is kept.
  assign frac_sh = (SUM_W-1)'(sum_p1 << shamt_w);
  assign ovf_w   = (e_w >= CW'(EXP_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2         <= 1'b0;
      abs_value_o    <= '0;
      round_sticky_o <= '0;
      overflow_o     <= 1'b0;
      sign_o         <= 1'b0;
      rnd_mode_o     <= '0;
      eff_sub_o      <= 1'b0;
      tag_o          <= '0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        abs_value_o    <= pack_sat(e_w, frac_sh[SUM_W-2 -: MAN_BITS]);
        round_sticky_o <= round_sticky(frac_sh[RS_W-1:0], sticky_p1, ovf_w);
        overflow_o     <= ovf_w;
        sign_o         <= sign_p1;
        rnd_mode_o     <= rnd_mode_p1;
        eff_sub_o      <= eff_sub_p1;
        tag_o          <= tag_p1;
      end
    end
  end

  assign valid_o = vld_p2;

endmodule

// File: tb/tb_rv_fp_normalize.sv
module tb_rv_fp_normalize;
  import rv_fp_normalize_pkg::*;

  localparam int EXP_BITS = 8;
  localparam int MAN_BITS = 23;
  localparam int SUM_W    = 51;
  localparam int TAG_W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [SUM_W-1:0]  sum_i = '0;
  logic [EXP_BITS:0] exp_i = 9'd1;
  logic              sticky_i = 1'b0;
  logic              sign_i = 1'b0;
  logic [2:0]        rnd_mode_i = INST_FRM_RNE;
  logic              eff_sub_i = 1'b0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b1;
  logic [30:0]       abs_value_o;
  logic [1:0]        round_sticky_o;
  logic              sign_o;
  logic [2:0]        rnd_mode_o;
  logic              eff_sub_o;
  logic [TAG_W-1:0]  tag_o;
  logic              overflow_o;

  int total = 0;
  int bad   = 0;

  rv_fp_normalize #(
    .EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS), .SUM_W(SUM_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .sum_i(sum_i), .exp_i(exp_i), .sticky_i(sticky_i), .sign_i(sign_i),
    .rnd_mode_i(rnd_mode_i), .eff_sub_i(eff_sub_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .abs_value_o(abs_value_o),
    .round_sticky_o(round_sticky_o), .sign_o(sign_o), .rnd_mode_o(rnd_mode_o),
    .eff_sub_o(eff_sub_o), .tag_o(tag_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && valid_i) assert (exp_i != 0) else $error("illegal exp_i=0 driven");
  end

  typedef struct packed {
    logic [30:0] abs;
    logic [1:0]  rs;
    logic        ov;
    logic        sg;
    logic [2:0]  rm;
    logic        es;
    logic [7:0]  tg;
  } beat_t;

  function automatic beat_t cur_out();
    beat_t o;
    o = {abs_value_o, round_sticky_o, overflow_o, sign_o, rnd_mode_o, eff_sub_o, tag_o};
    return o;
  endfunction

  // Reference: find the leading one by scanning, then renormalise.
  function automatic beat_t model(input logic [50:0] s, input logic [8:0] e, input logic st,
                                  input logic sg, input logic [2:0] rm, input logic es,
                                  input logic [7:0] tg);
    beat_t r;
    int lz, ex, sh;
    logic [50:0] t;
    lz = 0;
    while (lz < 51 && s[50-lz] == 1'b0) lz++;
    if (s != 0 && lz <= int'(e)) begin
      sh = lz; ex = int'(e) + 1 - lz;
    end else begin
      sh = (int'(e) > 51) ? 51 : int'(e); ex = 0;
    end
    t = s << sh;
    if (ex >= 255) begin
      r.abs = 31'h7F800000; r.rs = 2'b00; r.ov = 1'b1;
    end else begin
      r.abs = {ex[7:0], t[49:27]}; r.rs = {t[26], (|t[25:0]) | st}; r.ov = 1'b0;
    end
    r.sg = sg; r.rm = rm; r.es = es; r.tg = tg;
    return r;
  endfunction

  // Drives one beat with ready_i high and waits (bounded) for it to appear.
  task automatic run_beat(input logic [50:0] s, input logic [8:0] e, input logic st,
                          input logic [7:0] tg, output bit got, output int lat, output beat_t o);
    got = 0; lat = 0; o = '0;
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1; sum_i = s; exp_i = e; sticky_i = st;
    sign_i = tg[0]; rnd_mode_i = tg[3:1]; eff_sub_i = tg[4]; tag_i = tg;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) valid_i = 1'b0;
      if (valid_o === 1'b1) begin
        got = 1; lat = i; o = cur_out();
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    total++; if (cur_out() !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", cur_out()); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    bit got; int lat; beat_t o; beat_t w;
    run_beat(51'd1 << 49, 9'd127, 1'b0, 8'h5A, got, lat, o);
    w = '{abs: 31'h3F800000, rs: 2'b00, ov: 1'b0, sg: 1'b0, rm: 3'b101, es: 1'b1, tg: 8'h5A};
    total++; if (!got || lat != 2) begin bad++; $display("FAIL normal_latency got=%0d want=2 seen=%0d", lat, got); end
    total++; if (o !== w) begin bad++; $display("FAIL normal_value got=%h want=%h", o, w); end
    run_beat(51'd1 << 49, 9'd127, 1'b1, 8'h01, got, lat, o);
    total++; if (!got || o.rs !== 2'b01 || o.abs !== 31'h3F800000) begin
      bad++; $display("FAIL sticky_in got=%h/%b want=3f800000/01", o.abs, o.rs); end
  endtask

  task automatic test_carry_round();
    bit got; int lat; beat_t o;
    run_beat(51'd1 << 50, 9'd127, 1'b0, 8'h10, got, lat, o);
    total++; if (!got || o.abs !== 31'h40000000 || o.rs !== 2'b00 || o.ov !== 1'b0) begin
      bad++; $display("FAIL carry got=%h/%b/%b want=40000000/00/0", o.abs, o.rs, o.ov); end
    run_beat((51'd1 << 49) | (51'd1 << 25), 9'd127, 1'b0, 8'h11, got, lat, o);
    total++; if (!got || o.abs !== 31'h3F800000 || o.rs !== 2'b10) begin
      bad++; $display("FAIL round_bit got=%h/%b want=3f800000/10", o.abs, o.rs); end
  endtask

  task automatic test_subnormal_zero();
    bit got; int lat; beat_t o;
    run_beat(51'd1 << 40, 9'd3, 1'b0, 8'h22, got, lat, o);
    total++; if (!got || o.abs !== 31'h00010000 || o.rs !== 2'b00) begin
      bad++; $display("FAIL subnormal got=%h/%b want=00010000/00", o.abs, o.rs); end
    run_beat(51'd0, 9'd1, 1'b0, 8'h33, got, lat, o);
    total++; if (!got || o.abs !== 31'h0 || o.rs !== 2'b00 || o.tg !== 8'h33) begin
      bad++; $display("FAIL zero got=%h/%b/%h want=0/00/33", o.abs, o.rs, o.tg); end
  endtask

  task automatic test_overflow();
    bit got; int lat; beat_t o;
    run_beat(51'd1 << 50, 9'd254, 1'b1, 8'h44, got, lat, o);
    total++; if (!got || o.ov !== 1'b1 || o.abs !== 31'h7F800000 || o.rs !== 2'b00) begin
      bad++; $display("FAIL overflow got=%b/%h/%b want=1/7f800000/00", o.ov, o.abs, o.rs); end
    run_beat(51'd1 << 49, 9'd254, 1'b0, 8'h45, got, lat, o);
    total++; if (!got || o.ov !== 1'b0 || o.abs !== 31'h7F000000) begin
      bad++; $display("FAIL max_finite got=%b/%h want=0/7f000000", o.ov, o.abs); end
  endtask

  task automatic test_reset_midstream();
    int stale;
    ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; sum_i = 51'd1 << 49; exp_i = 9'd100; tag_i = 8'hA1;
    @(negedge clk);
    tag_i = 8'hA2;
    @(negedge clk);
    valid_i = 1'b0;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL inflight_valid got=%b want=1", valid_o); end
    reset = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", valid_o); end
    @(negedge clk);
    reset = 1'b0;
    total++; if (ready_o !== 1'b1 || tag_o !== 8'h00) begin
      bad++; $display("FAIL midreset_state ready=%b tag=%h want=1/00", ready_o, tag_o); end
    ready_i = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL stale_beat got=%0d want=0", stale); end
  endtask

  task automatic test_back_to_back();
    beat_t q[$];
    beat_t held, o, w;
    logic [63:0] rnd;
    bit have, hold;
    int sent, cyc, infl;
    localparam int N = 200;
    have = 0; hold = 0; sent = 0; cyc = 0; held = '0;
    while ((sent < N || q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        total++;
        if (valid_o !== 1'b1 || cur_out() !== held) begin
          bad++; $display("FAIL stall_stable got=%b/%h want=1/%h", valid_o, cur_out(), held); end
      end
      ready_i = ($urandom_range(0, 3) != 0);
      if (!have && sent < N && $urandom_range(0, 4) != 0) begin
        rnd = {$urandom, $urandom};
        sum_i = rnd[50:0] >> $urandom_range(0, 50);
        exp_i = 9'($urandom_range(1, 300));
        sticky_i = 1'($urandom_range(0, 1));
        sign_i = 1'($urandom_range(0, 1));
        rnd_mode_i = 3'($urandom_range(0, 4));
        eff_sub_i = 1'($urandom_range(0, 1));
        tag_i = 8'(sent);
        have = 1;
      end
      valid_i = have;
      #1;
      infl = q.size();
      if (infl < 2 || ready_i) begin
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL ready_room got=%b want=1 inflight=%0d", ready_o, infl); end
      end
      if (valid_o === 1'b1 && ready_i) begin
        o = cur_out();
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL unexpected_beat got=%h want=none", o);
        end else begin
          w = q.pop_front();
          if (o !== w) begin bad++; $display("FAIL stream_beat got=%h want=%h", o, w); end
        end
      end
      hold = (valid_o === 1'b1) && !ready_i;
      held = cur_out();
      if (valid_i && ready_o === 1'b1) begin
        q.push_back(model(sum_i, exp_i, sticky_i, sign_i, rnd_mode_i, eff_sub_i, tag_i));
        sent++;
        have = 0;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    total++;
    if (sent != N || q.size() != 0) begin
      bad++; $display("FAIL stream_done got=%0d/%0d want=%0d/0", sent, q.size(), N); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_carry_round();
    test_subnormal_zero();
    test_overflow();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
